timer_dev: RTL and testbench

- Memory-mapped countdown timer that sits directly downstream of the load/store formatting stage, behind the system bridge.
- Consumes the formatted store address, per-byte write enables and replicated write data. Returns read data for the load path.
- Raises an interrupt request to the CP0/exception unit on expiry.

---
 rtl/timer_dev.sv | 128 ++++++++++++
 tb/tb_timer_dev.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot / auto-reload modes and a level IRQ.
// Registers: CTRL (EN, MODE, IM), PRESET (reload value), COUNT (read-only).
`default_nettype none

module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        sel;
  logic [1:0]  idx;
  logic        wr;
  logic        ctrl_wr;
  logic        reload;
  logic        expire;

  assign sel     = (addr >= BASE_ADDR) && (addr <= BASE_ADDR + 32'd11);
  // Register index comes from the offset's low nibble only; sel already bounds the range.
  assign idx     = 2'((addr[3:0] - BASE_ADDR[3:0]) >> 2);
  assign wr      = sel && we && (byteen != 4'b0000);
  assign ctrl_wr = wr && (idx == 2'd0);
  assign reload  = (mode == 2'b01);
  assign expire  = (state == S_CNT) && en && (count <= 32'd1);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (en) state_nx = S_LOAD;
      S_LOAD: state_nx = S_CNT;
      S_CNT: begin
        if (!en)                    state_nx = S_IDLE;
        else if (count <= 32'd1)    state_nx = S_INT;
      end
      S_INT:  state_nx = reload ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Software writes to CTRL take priority over the one-shot EN clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= 1'b0;
      mode <= 2'b00;
      im   <= 1'b0;
    end else if (ctrl_wr && byteen[0]) begin
      en   <= wdata[0];
      mode <= wdata[2:1];
      im   <= wdata[3];
    end else if ((state == S_INT) && !reload) begin
      en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset <= 32'd0;
    end else if (wr && (idx == 2'd1)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteen[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'd0;
    end else if (state == S_LOAD) begin
      count <= preset;
    end else if ((state == S_CNT) && en) begin
      count <= (count > 32'd1) ? count - 32'd1 : 32'd0;
    end
  end

  // Any CTRL write clears the flag, even on the expiry edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             irq_flag <= 1'b0;
    else if (ctrl_wr)                      irq_flag <= 1'b0;
    else if (expire)                       irq_flag <= 1'b1;
    else if ((state == S_INT) && reload)   irq_flag <= 1'b0;
  end

  assign irq = irq_flag & im;

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (idx)
        2'd0:    rdata = {28'd0, im, mode, en};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev.
`timescale 1ns/1ps
`default_nettype none

module tb_timer_dev;

  localparam logic [31:0] B      = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = B;
  localparam logic [31:0] A_PRE  = B + 32'd4;
  localparam logic [31:0] A_CNT  = B + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  timer_dev #(.BASE_ADDR(B)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; byteen = be; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; byteen = 4'd0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rd("rst_ctrl", A_CTRL, 32'd0);
    rd("rst_pre", A_PRE, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick();

    // Asynchronous reset mid-count
    wr(A_PRE, 4'hF, 32'd100);
    wr(A_CTRL, 4'hF, 32'h1);
    repeat (10) tick();
    rd("run_cnt", A_CNT, 32'd92);
    #2 reset = 1'b1;
    #1;
    rd("arst_cnt", A_CNT, 32'd0);
    rd("arst_ctrl", A_CTRL, 32'd0);
    rd("arst_pre", A_PRE, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    rd("arst_idle", A_CNT, 32'd0);

    // One-shot, PRESET=5
    wr(A_PRE, 4'hF, 32'd5);
    wr(A_CTRL, 4'hF, 32'h9);           // edge T
    tick();                             // T+1 LOAD
    tick();                             // T+2
    rd("os_cnt5", A_CNT, 32'd5);
    for (int k = 4; k >= 1; k--) begin
      tick();
      rd($sformatf("os_cnt%0d", k), A_CNT, 32'(k));
      check("os_irq_lo", {31'd0, irq}, 32'd0);
    end
    tick();                             // T+7
    rd("os_cnt0", A_CNT, 32'd0);
    check("os_irq_hi", {31'd0, irq}, 32'd1);
    tick();                             // T+8
    rd("os_ctrl8", A_CTRL, 32'h8);
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    repeat (3) tick();
    check("os_irq_hold2", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 4'hF, 32'h0);
    check("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: 1-cycle pulse every 5 cycles
    wr(A_PRE, 4'hF, 32'd3);
    wr(A_CTRL, 4'hF, 32'hB);           // edge T
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("ar_irq_t%0d", k), {31'd0, irq}, (k % 5 == 0) ? 32'd1 : 32'd0);
    end
    wr(A_CTRL, 4'hF, 32'h0);
    repeat (4) tick();

    // Byte and halfword writes to PRESET
    wr(A_PRE, 4'hF, 32'd0);
    wr(B + 32'd5, 4'b0010, 32'hABAB_ABAB);
    rd("sb_pre", A_PRE, 32'h0000_AB00);
    wr(B + 32'd6, 4'b1100, 32'h1234_1234);
    rd("sh_pre", A_PRE, 32'h1234_AB00);
    wr(A_PRE, 4'b0000, 32'hFFFF_FFFF);
    rd("be0_pre", A_PRE, 32'h1234_AB00);

    // IM=0: expiry runs but irq stays low
    wr(A_PRE, 4'hF, 32'd2);
    wr(A_CTRL, 4'hF, 32'h1);           // edge T, expiry at T+4
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("im0_irq_t%0d", k), {31'd0, irq}, 32'd0);
    end
    rd("im0_cnt", A_CNT, 32'd0);
    rd("im0_ctrl", A_CTRL, 32'h0);
    wr(A_CTRL, 4'hF, 32'h0);

    // EN=0 during CNT: decrement on that edge, then frozen
    wr(A_PRE, 4'hF, 32'd50);
    wr(A_CTRL, 4'hF, 32'h1);           // edge T
    repeat (4) tick();                  // T+4
    rd("fz_cnt48", A_CNT, 32'd48);
    wr(A_CTRL, 4'hF, 32'h0);           // T+5
    rd("fz_cnt47a", A_CNT, 32'd47);
    repeat (3) tick();
    rd("fz_cnt47b", A_CNT, 32'd47);
    wr(A_CNT, 4'hF, 32'hFFFF_FFFF);
    rd("ro_cnt", A_CNT, 32'd47);

    // Out-of-range accesses
    wr(A_CTRL, 4'hF, 32'h8);
    wr(B + 32'h10, 4'hF, 32'h1);
    wr(B + 32'h14, 4'hF, 32'hDEAD_BEEF);
    wr(B - 32'd4, 4'hF, 32'h1);
    wr(B + 32'hC, 4'hF, 32'h1);
    rd("oor_ctrl", A_CTRL, 32'h8);
    rd("oor_pre", A_PRE, 32'd50);
    rd("rd_c", B + 32'hC, 32'd0);
    rd("rd_10", B + 32'h10, 32'd0);
    rd("ctrl_hi", A_CTRL + 32'd2, 32'h8);
    wr(A_CTRL, 4'hF, 32'h0);

    // PRESET=0: flag 2 cycles after LOAD
    wr(A_PRE, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h9);           // edge T, LOAD at T+1
    tick();
    tick();                             // T+2
    check("p0_irq_lo", {31'd0, irq}, 32'd0);
    tick();                             // T+3
    check("p0_irq_hi", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 4'hF, 32'h0);
    repeat (2) tick();

    // CTRL write on the expiry edge suppresses the flag
    wr(A_PRE, 4'hF, 32'd2);
    wr(A_CTRL, 4'hF, 32'h9);           // edge T, expiry at T+4
    repeat (3) tick();                  // T+3
    check("col_irq_pre", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 4'hF, 32'h9);           // T+4
    check("col_irq_exp", {31'd0, irq}, 32'd0);
    rd("col_cnt", A_CNT, 32'd0);
    tick();                             // T+5
    check("col_irq_after", {31'd0, irq}, 32'd0);
    rd("col_ctrl", A_CTRL, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
